// File: rtl/axis_unalign.sv
// axis_unalign: re-aligns LSB-aligned AXI-Stream packets so each packet starts
// at a per-packet byte lane offset. Bytes that spill past the beat boundary are
// carried into the next output beat, with one extra flush beat when the last
// input beat overflows.
module axis_unalign #(
  parameter int unsigned AXIS_DW = 64,
  parameter int unsigned AXIS_KW = ((AXIS_DW - 1) >> 3) + 1,
  parameter int unsigned OFF_W   = (AXIS_KW > 1) ? $clog2(AXIS_KW) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OFF_W-1:0]   s_offset,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [AXIS_DW-1:0] s_axis_tdata,
  input  logic [AXIS_KW-1:0] s_axis_tkeep,
  input  logic               s_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [AXIS_DW-1:0] m_axis_tdata,
  output logic [AXIS_KW-1:0] m_axis_tkeep,
  output logic               m_axis_tlast
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic [AXIS_DW-1:0]   res_data_q, res_data_d;
  logic [AXIS_KW-1:0]   res_keep_q, res_keep_d;
  logic [AXIS_DW-1:0]   m_data_q, m_data_d;
  logic [AXIS_KW-1:0]   m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;
  logic                 m_valid_q, m_valid_d;

  logic                 ld_c;
  logic                 accept_c;
  logic [OFF_W-1:0]     off_c;
  logic [2*AXIS_DW-1:0] win_data_c;
  logic [2*AXIS_KW-1:0] win_keep_c;
  logic [AXIS_DW-1:0]   carry_data_c;
  logic [AXIS_KW-1:0]   carry_keep_c;

  // Output stage can take a new beat when empty or draining this cycle.
  assign ld_c          = !m_valid_q || m_axis_tready;
  assign s_axis_tready = ld_c && (state_q != FLUSH);
  assign accept_c      = s_axis_tvalid && s_axis_tready;

  // First beat of a packet uses the live offset; later beats the latched one.
  assign off_c = (state_q == IDLE) ? s_offset : off_q;

  // Shift the input beat into a two-beat window by off bytes.
  assign win_data_c = {{AXIS_DW{1'b0}}, s_axis_tdata} << {off_c, 3'b000};
  assign win_keep_c = {{AXIS_KW{1'b0}}, s_axis_tkeep} << off_c;

  // Residual from the previous beat only applies inside an open packet.
  assign carry_data_c = (state_q == ACTIVE) ? res_data_q : '0;
  assign carry_keep_c = (state_q == ACTIVE) ? res_keep_q : '0;

  // Next-state, residual and output-stage logic.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    res_data_d = res_data_q;
    res_keep_d = res_keep_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q && !m_axis_tready;

    if (state_q == FLUSH) begin
      if (ld_c) begin
        m_valid_d  = 1'b1;
        m_data_d   = res_data_q;
        m_keep_d   = res_keep_q;
        m_last_d   = 1'b1;
        res_data_d = '0;
        res_keep_d = '0;
        state_d    = IDLE;
      end
    end else if (accept_c) begin
      if (state_q == IDLE) begin
        off_d = s_offset;
      end
      m_valid_d  = 1'b1;
      m_data_d   = win_data_c[AXIS_DW-1:0] | carry_data_c;
      m_keep_d   = win_keep_c[AXIS_KW-1:0] | carry_keep_c;
      res_data_d = win_data_c[2*AXIS_DW-1:AXIS_DW];
      res_keep_d = win_keep_c[2*AXIS_KW-1:AXIS_KW];
      if (!s_axis_tlast) begin
        m_last_d = 1'b0;
        state_d  = ACTIVE;
      end else if (win_keep_c[2*AXIS_KW-1:AXIS_KW] != '0) begin
        m_last_d = 1'b0;
        state_d  = FLUSH;
      end else begin
        m_last_d = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  // State, residual and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      off_q      <= '0;
      res_data_q <= '0;
      res_keep_q <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      res_data_q <= res_data_d;
      res_keep_q <= res_keep_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_axis_unalign.sv
// Testbench for axis_unalign (64-bit data, 8 byte lanes).
module tb_axis_unalign;

  logic        clk;
  logic        rst_n;
  logic [2:0]  s_offset;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;

  axis_unalign #(.AXIS_DW(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_offset      (s_offset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // Input beats to drive and expected/actual output beats.
  logic [63:0] in_d[$];
  logic [7:0]  in_k[$];
  bit          in_l[$];
  logic [2:0]  in_o[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_k[$];
  bit          exp_l[$];
  logic [63:0] act_d[$];
  logic [7:0]  act_k[$];
  bit          act_l[$];

  int   rdy_mode;
  int   cyc;
  int   first_acc_cyc;
  int   first_out_cyc;
  int   stall_err;
  int   tready_err;
  int   flush_stalls;
  bit   stall_prev;
  logic [63:0] prev_d;
  logic [7:0]  prev_k;
  logic        prev_l;

  task automatic clr();
    in_d.delete(); in_k.delete(); in_l.delete(); in_o.delete();
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    act_d.delete(); act_k.delete(); act_l.delete();
    first_acc_cyc = -1;
    first_out_cyc = -1;
    stall_err     = 0;
    tready_err    = 0;
    flush_stalls  = 0;
  endtask

  // Reference model: packet of n bytes placed at lane off of a byte stream.
  task automatic add_pkt(input int n, input int off, input int mid_off,
                         input bit rnd, input int start);
    byte unsigned b[$];
    int nb, ob, idx, g;
    logic [63:0] d;
    logic [7:0]  k;
    for (int i = 0; i < n; i++) b.push_back(rnd ? 8'($urandom) : 8'(start + i));
    nb = (n + 7) / 8;
    for (int bt = 0; bt < nb; bt++) begin
      d = '0; k = '0;
      for (int l = 0; l < 8; l++) begin
        idx = bt * 8 + l;
        if (idx < n) begin d[l*8 +: 8] = b[idx]; k[l] = 1'b1; end
      end
      in_d.push_back(d); in_k.push_back(k); in_l.push_back(bt == nb - 1);
      in_o.push_back(bt == 0 ? 3'(off) : (mid_off < 0 ? 3'($urandom_range(0, 7)) : 3'(mid_off)));
    end
    ob = (off + n + 7) / 8;
    for (int bt = 0; bt < ob; bt++) begin
      d = '0; k = '0;
      for (int l = 0; l < 8; l++) begin
        g = bt * 8 + l;
        if (g >= off && g < off + n) begin d[l*8 +: 8] = b[g - off]; k[l] = 1'b1; end
      end
      exp_d.push_back(d); exp_k.push_back(k); exp_l.push_back(bt == ob - 1);
    end
  endtask

  // One clock cycle: entered just after a negedge with s_* inputs set.
  task automatic step(output bit acc);
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 3 == 0);
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    acc = s_tvalid && s_tready;
    if (stall_prev && (m_tvalid !== 1'b1 || m_tdata !== prev_d ||
                       m_tkeep !== prev_k || m_tlast !== prev_l))
      stall_err++;
    if (m_tvalid && !m_tready && s_tready) tready_err++;
    if (s_tvalid && !s_tready && m_tready) flush_stalls++;
    if (m_tvalid && m_tready) begin
      act_d.push_back(m_tdata); act_k.push_back(m_tkeep); act_l.push_back(m_tlast);
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    if (acc && first_acc_cyc < 0) first_acc_cyc = cyc;
    stall_prev = m_tvalid && !m_tready;
    prev_d = m_tdata; prev_k = m_tkeep; prev_l = m_tlast;
    @(negedge clk);
    cyc++;
  endtask

  // Drive all queued input beats, then drain expected outputs (bounded).
  task automatic run(input bit vgap);
    int i = 0;
    int budget = 0;
    bit acc;
    while (i < in_d.size() && budget < 4000) begin
      if (vgap && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
      end else begin
        s_tvalid = 1'b1;
        s_tdata = in_d[i]; s_tkeep = in_k[i]; s_tlast = in_l[i]; s_offset = in_o[i];
      end
      step(acc);
      if (acc) i++;
      budget++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    budget = 0;
    while (act_d.size() < exp_d.size() && budget < 200) begin
      step(acc);
      budget++;
    end
    repeat (2) step(acc);
  endtask

  task automatic test_reset();
    s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_offset = '0;
    m_tready = 0; rst_n = 0; cyc = 0; stall_prev = 0;
    repeat (2) @(negedge clk);
    ntot++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); else npass++;
    ntot++; if (m_tdata !== 64'h0) $display("FAIL reset_tdata got=%h exp=0", m_tdata); else npass++;
    ntot++; if (m_tkeep !== 8'h00) $display("FAIL reset_tkeep got=%h exp=00", m_tkeep); else npass++;
    ntot++; if (m_tlast !== 1'b0) $display("FAIL reset_tlast got=%b exp=0", m_tlast); else npass++;
    rst_n = 1;
    @(negedge clk);
    ntot++; if (s_tready !== 1'b1) $display("FAIL reset_tready got=%b exp=1", s_tready); else npass++;
  endtask

  task automatic test_offset0();
    clr(); rdy_mode = 0;
    add_pkt(20, 0, -1, 0, 8'h10);
    run(0);
    ntot++;
    if (act_d.size() !== 3 || exp_d.size() !== 3)
      $display("FAIL off0_count got=%0d exp=3", act_d.size());
    else npass++;
    for (int j = 0; j < act_d.size() && j < exp_d.size(); j++) begin
      ntot++;
      if (act_d[j] !== in_d[j] || act_k[j] !== in_k[j] || act_l[j] !== in_l[j])
        $display("FAIL off0_beat%0d got=%h/%h/%b exp=%h/%h/%b", j, act_d[j], act_k[j], act_l[j],
                 in_d[j], in_k[j], in_l[j]);
      else npass++;
    end
    ntot++;
    if (first_out_cyc !== first_acc_cyc + 1)
      $display("FAIL off0_latency got=%0d exp=%0d", first_out_cyc, first_acc_cyc + 1);
    else npass++;
  endtask

  task automatic test_single_offset3();
    clr(); rdy_mode = 0;
    add_pkt(5, 3, -1, 0, 8'h01);
    run(0);
    ntot++;
    if (act_d.size() !== 1 || act_k[0] !== 8'hF8 || act_d[0] !== 64'h0504_0302_0100_0000 || act_l[0] !== 1'b1)
      $display("FAIL single_off3 got n=%0d %h/%h", act_d.size(),
               act_d.size() ? act_d[0] : 64'h0, act_k.size() ? act_k[0] : 8'h0);
    else npass++;
  endtask

  task automatic test_flush();
    clr(); rdy_mode = 0;
    add_pkt(14, 3, -1, 0, 8'h00);
    add_pkt(8, 0, -1, 0, 8'hA0);
    run(0);
    ntot++;
    if (act_d.size() !== exp_d.size())
      $display("FAIL flush_count got=%0d exp=%0d", act_d.size(), exp_d.size());
    else npass++;
    for (int j = 0; j < act_d.size() && j < exp_d.size(); j++) begin
      ntot++;
      if (act_d[j] !== exp_d[j] || act_k[j] !== exp_k[j] || act_l[j] !== exp_l[j])
        $display("FAIL flush_beat%0d got=%h/%h/%b exp=%h/%h/%b", j, act_d[j], act_k[j], act_l[j],
                 exp_d[j], exp_k[j], exp_l[j]);
      else npass++;
    end
    ntot++;
    if (act_k.size() > 2 && (act_k[2] !== 8'h01 || act_d[2][7:0] !== 8'h0D))
      $display("FAIL flush_residual got=%h/%h exp=01/0d", act_k[2], act_d[2][7:0]);
    else npass++;
    ntot++;
    if (flush_stalls !== 1) $display("FAIL flush_tready_low got=%0d exp=1", flush_stalls); else npass++;
  endtask

  task automatic test_backpressure();
    clr(); rdy_mode = 1;
    add_pkt(14, 3, -1, 0, 8'h00);
    add_pkt(30, 6, -1, 1, 0);
    run(0);
    ntot++;
    if (act_d.size() !== exp_d.size())
      $display("FAIL bp_count got=%0d exp=%0d", act_d.size(), exp_d.size());
    else npass++;
    for (int j = 0; j < act_d.size() && j < exp_d.size(); j++) begin
      ntot++;
      if (act_d[j] !== exp_d[j] || act_k[j] !== exp_k[j] || act_l[j] !== exp_l[j])
        $display("FAIL bp_beat%0d got=%h/%h/%b exp=%h/%h/%b", j, act_d[j], act_k[j], act_l[j],
                 exp_d[j], exp_k[j], exp_l[j]);
      else npass++;
    end
    ntot++; if (stall_err !== 0) $display("FAIL bp_hold got=%0d exp=0", stall_err); else npass++;
    ntot++; if (tready_err !== 0) $display("FAIL bp_tready got=%0d exp=0", tready_err); else npass++;
  endtask

  task automatic test_back_to_back();
    clr(); rdy_mode = 0;
    add_pkt(20, 5, 7, 1, 0);
    add_pkt(13, 2, 7, 1, 0);
    run(0);
    ntot++;
    if (act_d.size() !== exp_d.size())
      $display("FAIL b2b_count got=%0d exp=%0d", act_d.size(), exp_d.size());
    else npass++;
    for (int j = 0; j < act_d.size() && j < exp_d.size(); j++) begin
      ntot++;
      if (act_d[j] !== exp_d[j] || act_k[j] !== exp_k[j] || act_l[j] !== exp_l[j])
        $display("FAIL b2b_beat%0d got=%h/%h/%b exp=%h/%h/%b", j, act_d[j], act_k[j], act_l[j],
                 exp_d[j], exp_k[j], exp_l[j]);
      else npass++;
    end
    ntot++;
    if (act_k.size() < 5 || act_k[4] !== 8'hFC)
      $display("FAIL b2b_second_first_keep got=%h exp=fc", act_k.size() > 4 ? act_k[4] : 8'h00);
    else npass++;
    ntot++;
    if (flush_stalls !== 1) $display("FAIL b2b_idle_cycles got=%0d exp=1", flush_stalls); else npass++;
  endtask

  task automatic test_random();
    clr(); rdy_mode = 2;
    for (int p = 0; p < 25; p++) add_pkt($urandom_range(1, 40), $urandom_range(0, 7), -1, 1, 0);
    run(1);
    ntot++;
    if (act_d.size() !== exp_d.size())
      $display("FAIL rnd_count got=%0d exp=%0d", act_d.size(), exp_d.size());
    else npass++;
    for (int j = 0; j < act_d.size() && j < exp_d.size(); j++) begin
      ntot++;
      if (act_d[j] !== exp_d[j] || act_k[j] !== exp_k[j] || act_l[j] !== exp_l[j])
        $display("FAIL rnd_beat%0d got=%h/%h/%b exp=%h/%h/%b", j, act_d[j], act_k[j], act_l[j],
                 exp_d[j], exp_k[j], exp_l[j]);
      else npass++;
    end
    ntot++; if (stall_err !== 0) $display("FAIL rnd_hold got=%0d exp=0", stall_err); else npass++;
    ntot++; if (tready_err !== 0) $display("FAIL rnd_tready got=%0d exp=0", tready_err); else npass++;
  endtask

  task automatic test_reset_mid();
    bit acc;
    clr(); rdy_mode = 0;
    add_pkt(24, 2, -1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1; s_tdata = in_d[i]; s_tkeep = in_k[i]; s_tlast = in_l[i]; s_offset = in_o[i];
      step(acc);
    end
    s_tvalid = 0;
    ntot++; if (m_tvalid !== 1'b1) $display("FAIL rstmid_pre_valid got=%b exp=1", m_tvalid); else npass++;
    #1 rst_n = 0;
    #1;
    ntot++; if (m_tvalid !== 1'b0) $display("FAIL rstmid_tvalid got=%b exp=0", m_tvalid); else npass++;
    ntot++; if (m_tkeep !== 8'h00) $display("FAIL rstmid_tkeep got=%h exp=00", m_tkeep); else npass++;
    @(negedge clk);
    rst_n = 1;
    stall_prev = 0;
    @(negedge clk);
    clr();
    add_pkt(10, 1, -1, 1, 0);
    run(0);
    ntot++;
    if (act_d.size() !== exp_d.size())
      $display("FAIL rstmid_count got=%0d exp=%0d", act_d.size(), exp_d.size());
    else npass++;
    for (int j = 0; j < act_d.size() && j < exp_d.size(); j++) begin
      ntot++;
      if (act_d[j] !== exp_d[j] || act_k[j] !== exp_k[j] || act_l[j] !== exp_l[j])
        $display("FAIL rstmid_beat%0d got=%h/%h/%b exp=%h/%h/%b", j, act_d[j], act_k[j], act_l[j],
                 exp_d[j], exp_k[j], exp_l[j]);
      else npass++;
    end
    ntot++;
    if (act_k.size() < 1 || act_k[0] !== 8'hFE)
      $display("FAIL rstmid_first_keep got=%h exp=fe", act_k.size() ? act_k[0] : 8'h00);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_offset0();
    test_single_offset3();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
